// File: rtl/pt_feedback_pkg.sv
// Shared widths and timing constants for the pt_feedback chain.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pt_feedback_pkg;

  // Decimator output word: 14-bit input + 4 bits growth - 1
  localparam int DEC_DATA_WIDTH     = 17;
  // Delay line depth is 2^DELAY_ADDR_WIDTH; max delay is one less
  localparam int DELAY_ADDR_WIDTH   = 10;
  // ce_i -> ce_o latency of the delay line, used by downstream alignment
  localparam int DELAY_LINE_LATENCY = 2;

endpackage

// File: rtl/decimated_delay_line_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data valid 1 clk after rd_en; write visible to reads on later cycles.
// Backpressure: none; accepts a write and a read every clk.
module sdp_ram #(
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Storage array and read register; no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/decimated_delay_line.sv
// Programmable whole-sample delay of the decimated stream, with fill gating.
// Latency: fixed 2 clk from ce_i to ce_o for every delay, including zero.
// Backpressure: none; full rate of one sample per clk, never stalls.
module decimated_delay_line
  import pt_feedback_pkg::*;
#(
  parameter int DATA_WIDTH = DEC_DATA_WIDTH,
  parameter int ADDR_WIDTH = DELAY_ADDR_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         ce_i,
  input  logic        [ADDR_WIDTH-1:0] delay_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         ce_o,
  output logic                         filled_o
);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Stage-1 registers, aligned with the RAM read data
  logic                  s1_vld;
  logic                  s1_bypass;
  logic                  s1_empty;
  logic [DATA_WIDTH-1:0] s1_bypass_dat;

  // Oldest wanted sample sits d slots behind the slot being written now
  assign rd_addr = wr_ptr - delay_i;

  sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (ce_i),
    .wr_addr (wr_ptr),
    .wr_data (data_i),
    .rd_en   (ce_i),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  // Write pointer wraps naturally; fill count saturates at the max delay
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else if (ce_i) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill_cnt != '1) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Register bypass and gate decisions using the pre-increment fill count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld        <= 1'b0;
      s1_bypass     <= 1'b0;
      s1_empty      <= 1'b0;
      s1_bypass_dat <= '0;
    end else begin
      s1_vld <= ce_i;
      if (ce_i) begin
        s1_bypass     <= (delay_i == '0);
        s1_empty      <= (fill_cnt < delay_i);
        s1_bypass_dat <= data_i;
      end
    end
  end

  // Output stage: zero when not yet backed by real samples, else bypass or RAM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o   <= '0;
      ce_o     <= 1'b0;
      filled_o <= 1'b0;
    end else begin
      ce_o <= s1_vld;
      if (s1_vld) begin
        filled_o <= !s1_empty;
        if (s1_empty)       data_o <= '0;
        else if (s1_bypass) data_o <= s1_bypass_dat;
        else                data_o <= ram_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_decimated_delay_line.sv
// Directed self-checking bench for decimated_delay_line.
// Latency: expects ce_o exactly 2 clk after each ce_i.
// Backpressure: none exercised; stream runs at up to one sample per clk.
module tb_decimated_delay_line;
  import pt_feedback_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;

  // Default-size instance
  logic signed [16:0] data = '0;
  logic               ce = 1'b0;
  logic [9:0]         delay = '0;
  logic signed [16:0] data_o;
  logic               ce_o;
  logic               filled_o;

  // Small instance (16-deep) for pointer wrap at full rate
  logic signed [16:0] b_data = '0;
  logic               b_ce = 1'b0;
  logic [3:0]         b_delay = '0;
  logic signed [16:0] b_data_o;
  logic               b_ce_o;
  logic               b_filled_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decimated_delay_line dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .data_i   (data),
    .ce_i     (ce),
    .delay_i  (delay),
    .data_o   (data_o),
    .ce_o     (ce_o),
    .filled_o (filled_o)
  );

  decimated_delay_line #(.DATA_WIDTH(17), .ADDR_WIDTH(4)) dut_small (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .data_i   (b_data),
    .ce_i     (b_ce),
    .delay_i  (b_delay),
    .data_o   (b_data_o),
    .ce_o     (b_ce_o),
    .filled_o (b_filled_o)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ce = 1'b0;
    b_ce = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One strobe, then check the 2-clk latency, the output word and its hold
  task automatic strobe(input string tag, input logic signed [16:0] din,
                        input logic [9:0] dly, input logic signed [16:0] exp_d,
                        input logic exp_f, input int gap);
    @(negedge clk);
    ce = 1'b1;
    data = din;
    delay = dly;
    @(negedge clk);
    ce = 1'b0;
    check({tag, "_ce_early"}, 32'(ce_o), 0);
    @(negedge clk);
    check({tag, "_ce"}, 32'(ce_o), 1);
    check({tag, "_dat"}, 32'(data_o), 32'(exp_d));
    check({tag, "_fil"}, 32'(filled_o), 32'(exp_f));
    @(negedge clk);
    check({tag, "_ce_one"}, 32'(ce_o), 0);
    check({tag, "_hold"}, 32'(data_o), 32'(exp_d));
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    logic signed [16:0] t2_exp [6];
    logic signed [16:0] t4_exp [10];
    logic signed [16:0] t6_in  [5];
    t2_exp = '{0, 0, 0, 1, 2, 3};
    t4_exp = '{0, 0, 10, 20, 30, 10, 20, 30, 40, 50};
    t6_in  = '{21, 22, 23, 24, 25};

    // Reset state, observed while reset is held
    repeat (2) @(negedge clk);
    check("rst_dat", 32'(data_o), 0);
    check("rst_ce", 32'(ce_o), 0);
    check("rst_fil", 32'(filled_o), 0);
    check("rst_latency_const", DELAY_LINE_LATENCY, 2);
    rst_n = 1'b1;

    // Zero delay: bypass path, filled from the first strobe
    strobe("t1_a", 17'sd100, 10'd0, 17'sd100, 1'b1, 12);
    strobe("t1_b", -17'sd100, 10'd0, -17'sd100, 1'b1, 12);
    strobe("t1_c", 17'sd200, 10'd0, 17'sd200, 1'b1, 12);

    // Delay 3 from a clean start: three gated zeros, then the stream
    do_reset();
    for (int i = 0; i < 6; i++)
      strobe($sformatf("t2_%0d", i), 17'(i + 1), 10'd3, t2_exp[i], i >= 3, 12);

    // Delay 15 in a 16-deep buffer, back-to-back strobes, pointer wraps twice
    do_reset();
    b_delay = 4'd15;
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check($sformatf("t3_ce_%0d", k - 2), 32'(b_ce_o), 1);
        check($sformatf("t3_dat_%0d", k - 2), 32'(b_data_o),
              (k - 2 >= 15) ? k - 17 : 0);
        check($sformatf("t3_fil_%0d", k - 2), 32'(b_filled_o),
              (k - 2 >= 15) ? 1 : 0);
      end
      b_ce = (k < 40);
      b_data = 17'(k);
    end
    @(negedge clk);
    check("t3_ce_stop", 32'(b_ce_o), 0);

    // Delay change 2 -> 5 applied with the sample 60 strobe
    do_reset();
    for (int i = 0; i < 10; i++)
      strobe($sformatf("t4_%0d", i), 17'((i + 1) * 10), (i >= 5) ? 10'd5 : 10'd2,
             t4_exp[i], i >= 2, 4);

    // Full-scale values survive bit-exact
    do_reset();
    strobe("t5_a", -17'sd65536, 10'd1, 17'sd0, 1'b0, 4);
    strobe("t5_b", 17'sd65535, 10'd1, -17'sd65536, 1'b1, 4);
    strobe("t5_c", 17'sd0, 10'd1, 17'sd65535, 1'b1, 4);

    // Reset pulse with a sample in flight
    do_reset();
    for (int i = 0; i < 5; i++)
      strobe($sformatf("t6_pre_%0d", i), 17'(11 + i), 10'd4,
             (i == 4) ? 17'sd11 : 17'sd0, i == 4, 2);
    @(negedge clk);
    ce = 1'b1;
    data = 17'sd16;
    @(negedge clk);
    ce = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_dat", 32'(data_o), 0);
    check("t6_rst_fil", 32'(filled_o), 0);
    @(negedge clk);
    check("t6_rst_ce", 32'(ce_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_ce", 32'(ce_o), 0);
    check("t6_post_dat", 32'(data_o), 0);
    for (int i = 0; i < 5; i++)
      strobe($sformatf("t6_post_%0d", i), t6_in[i], 10'd4,
             (i == 4) ? 17'sd21 : 17'sd0, i == 4, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
